// File: rtl/audio_out_serializer.sv
// Audio DAC serializer: two sample FIFOs (left/right) feeding a left-justified,
// MSB-first serial stream aligned to the LRCK edge strobes.
module audio_out_serializer #(
    parameter int AUDIO_DATA_WIDTH = 21,
    parameter int FIFO_DEPTH       = 128,
    parameter int FIFO_ADDR_WIDTH  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bit_clk_rising_edge,
    input  logic                      bit_clk_falling_edge,
    input  logic                      left_right_clk_rising_edge,
    input  logic                      left_right_clk_falling_edge,
    input  logic [AUDIO_DATA_WIDTH:1] left_channel_data,
    input  logic                      left_channel_data_en,
    input  logic [AUDIO_DATA_WIDTH:1] right_channel_data,
    input  logic                      right_channel_data_en,
    output logic [7:0]                left_channel_fifo_write_space,
    output logic [7:0]                right_channel_fifo_write_space,
    output logic                      serial_audio_out_data
);
    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [7:0]               DEPTH_8   = 8'(FIFO_DEPTH);
    localparam logic [CW-1:0]            CNT_LOAD  = CW'(W - 1);

    logic [1:0]   ch_wr_en;
    logic [W:1]   ch_wr_data [2];
    logic [W:1]   ch_head    [2];
    logic [7:0]   ch_space   [2];
    logic [1:0]   ch_nonempty;
    logic         pop;
    logic         unused_inputs;

    assign ch_wr_en      = {right_channel_data_en, left_channel_data_en};
    assign ch_wr_data[0] = left_channel_data;
    assign ch_wr_data[1] = right_channel_data;
    assign unused_inputs = bit_clk_rising_edge;

    // Both channels pop together or not at all, so they can never drift apart.
    assign pop = left_right_clk_rising_edge & (&ch_nonempty);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [W:1]                 mem [FIFO_DEPTH];
            logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
            logic [FIFO_ADDR_WIDTH:0]   used_reg, used_next;
            logic [W:1]                 head_reg;
            logic [7:0]                 space_reg;
            logic                       wr_ok;

            assign wr_ok       = ch_wr_en[gi] && (used_reg != DEPTH_CNT);
            assign rd_ptr_next = rd_ptr_reg + {{(FIFO_ADDR_WIDTH-1){1'b0}}, pop};

            always_comb begin
                used_next = used_reg;
                if (wr_ok && !pop)
                    used_next = used_reg + 1'b1;
                else if (!wr_ok && pop)
                    used_next = used_reg - 1'b1;
            end

            always_ff @(posedge clk) begin
                if (wr_ok)
                    mem[wr_ptr_reg] <= ch_wr_data[gi];
            end

            // head_reg pre-reads the next word; bypass covers a write landing on the head slot.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    used_reg   <= '0;
                    head_reg   <= '0;
                    space_reg  <= '0;
                end else begin
                    if (wr_ok)
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    rd_ptr_reg <= rd_ptr_next;
                    used_reg   <= used_next;
                    if (wr_ok && (wr_ptr_reg == rd_ptr_next))
                        head_reg <= ch_wr_data[gi];
                    else
                        head_reg <= mem[rd_ptr_next];
                    space_reg  <= DEPTH_8 - 8'(used_reg);
                end
            end

            assign ch_nonempty[gi] = (used_reg != '0);
            assign ch_head[gi]     = head_reg;
            assign ch_space[gi]    = space_reg;
        end
    endgenerate

    assign left_channel_fifo_write_space  = ch_space[0];
    assign right_channel_fifo_write_space = ch_space[1];

    // The MSB leaves on the load cycle, so the shifter only keeps the remaining W-1 bits.
    logic [W-1:1]  shift_reg;
    logic [W:1]    hold_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic          serial_reg;
    logic [W:1]    left_word, right_word;

    assign left_word  = pop ? ch_head[0] : '0;
    assign right_word = pop ? ch_head[1] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            hold_reg    <= '0;
            bit_cnt_reg <= '0;
            serial_reg  <= 1'b0;
        end else if (left_right_clk_rising_edge) begin
            shift_reg   <= left_word[W-1:1];
            hold_reg    <= right_word;
            serial_reg  <= left_word[W];
            bit_cnt_reg <= CNT_LOAD;
        end else if (left_right_clk_falling_edge) begin
            shift_reg   <= hold_reg[W-1:1];
            serial_reg  <= hold_reg[W];
            bit_cnt_reg <= CNT_LOAD;
        end else if (bit_clk_falling_edge) begin
            if (bit_cnt_reg != '0) begin
                serial_reg  <= shift_reg[W-1];
                shift_reg   <= {shift_reg[W-2:1], 1'b0};
                bit_cnt_reg <= bit_cnt_reg - 1'b1;
            end else begin
                serial_reg  <= 1'b0;
            end
        end
    end

    assign serial_audio_out_data = serial_reg;

endmodule
